cpu_wrbuf: RTL

CPU_WRBUF -- requirements
Module: cpu_wrbuf

---
 rtl/minimig_cpu_pkg.sv | 36 +++
 rtl/cpu_wrbuf_fifo.sv | 56 +++++
 rtl/cpu_wrbuf.sv | 137 +++++++++++++
 3 files changed

// File: rtl/minimig_cpu_pkg.sv
`default_nettype none
// ============================================================================
// minimig_cpu_pkg : shared CPU-bus encodings, write-buffer FSM states, entry type
// Rev 1.0
// ============================================================================
package minimig_cpu_pkg;

  typedef enum logic [1:0] {
    CS_FETCH = 2'b00,
    CS_IDLE  = 2'b01,
    CS_READ  = 2'b10,
    CS_WRITE = 2'b11
  } cpustate_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_WR_GAP   = 2'd2,
    ST_RD_ISSUE = 2'd3
  } wrbuf_state_e;

  typedef struct packed {
    logic [25:1] addr;
    logic        l;
    logic        u;
    logic [15:0] data;
  } wrbuf_entry_t;

  localparam int unsigned WRBUF_ENTRY_W = $bits(wrbuf_entry_t);

  function automatic logic is_read(input logic [1:0] cs);
    return (cs == CS_FETCH) || (cs == CS_READ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_wrbuf_fifo.sv
`default_nettype none
// ============================================================================
// cpu_wrbuf_fifo : synchronous DEPTH x WIDTH FIFO with occupancy count
// Rev 1.0
// ============================================================================
module cpu_wrbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 43,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cpu_wrbuf.sv
`default_nettype none
// ============================================================================
// cpu_wrbuf : posted-write buffer between CPU bus and sdram_ctrl CPU port
// Rev 1.0
// ============================================================================
module cpu_wrbuf
  import minimig_cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        sysclk,
  input  logic        reset_n,
  input  logic        wrbuf_en,
  input  logic [25:1] cpuAddr,
  input  logic [1:0]  cpustate,
  input  logic        cpu_ncs,
  input  logic        cpuL,
  input  logic        cpuU,
  input  logic [15:0] cpuWR,
  output logic [15:0] cpuRD,
  output logic        cpuena,
  input  logic        enaWRreg,
  output logic [25:1] ramAddr,
  output logic [1:0]  ramstate,
  output logic        ram_ncs,
  output logic        ramL,
  output logic        ramU,
  output logic [15:0] ramWR,
  input  logic [15:0] ramRD,
  input  logic        ramena,
  output logic        wrbuf_empty
);

  localparam int AW = $clog2(DEPTH);

  wrbuf_state_e       state_q;
  logic               ack_pend_q;
  logic [15:0]        cpurd_q;

  wrbuf_entry_t       w_wentry;
  wrbuf_entry_t       w_head;
  logic [WRBUF_ENTRY_W-1:0] w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [AW:0]        w_fifo_count;
  logic               w_accept;
  logic               w_pop;
  logic               w_direct_req;

  assign w_wentry = '{addr: cpuAddr, l: cpuL, u: cpuU, data: cpuWR};
  assign w_head   = wrbuf_entry_t'(w_fifo_rdata);

  assign w_accept = wrbuf_en && (cpustate == CS_WRITE) && !cpu_ncs
                    && !w_fifo_full && !ack_pend_q;
  assign w_pop    = (state_q == ST_WR_ISSUE) && ramena;

  // Requests serviced straight through: reads/fetches, and writes while buffering is off.
  assign w_direct_req = !cpu_ncs && !ack_pend_q
                        && (is_read(cpustate) || (!wrbuf_en && (cpustate == CS_WRITE)));

  cpu_wrbuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WRBUF_ENTRY_W)
  ) u_fifo (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .push_i  (w_accept),
    .pop_i   (w_pop),
    .wdata_i (w_wentry),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .count_o (w_fifo_count)
  );

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ack_pend_q <= 1'b0;
      cpurd_q    <= '0;
    end else begin
      if (w_accept)                    ack_pend_q <= 1'b1;
      else if (ack_pend_q && enaWRreg) ack_pend_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Buffered writes always go first so a read never overtakes one.
          if (!w_fifo_empty)     state_q <= ST_WR_ISSUE;
          else if (w_direct_req) state_q <= ST_RD_ISSUE;
        end
        ST_WR_ISSUE: if (ramena) state_q <= ST_WR_GAP;
        ST_WR_GAP:   state_q <= ST_IDLE;
        ST_RD_ISSUE: begin
          if (ramena) begin
            cpurd_q <= ramRD;
            state_q <= ST_IDLE;
          end
        end
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_ncs  = 1'b1;
    ramstate = CS_IDLE;
    ramAddr  = '0;
    ramL     = 1'b1;
    ramU     = 1'b1;
    ramWR    = '0;
    case (state_q)
      ST_WR_ISSUE: begin
        ram_ncs  = 1'b0;
        ramstate = CS_WRITE;
        ramAddr  = w_head.addr;
        ramL     = w_head.l;
        ramU     = w_head.u;
        ramWR    = w_head.data;
      end
      ST_RD_ISSUE: begin
        ram_ncs  = 1'b0;
        ramstate = cpustate;
        ramAddr  = cpuAddr;
        ramL     = cpuL;
        ramU     = cpuU;
        ramWR    = cpuWR;
      end
      default: ;
    endcase
  end

  assign cpuena      = ack_pend_q || ((state_q == ST_RD_ISSUE) && ramena);
  assign cpuRD       = (state_q == ST_RD_ISSUE) ? ramRD : cpurd_q;
  assign wrbuf_empty = w_fifo_empty && (state_q != ST_WR_ISSUE);

endmodule
`default_nettype wire
